uart_xcvr_p: RTL and testbench

Parametrised successor to the fixed-format UART: a full-duplex transceiver with data width set at elaboration and parity mode, stop-bit count and baud divisor set at run time.
- Receiver samples at 16x oversampling and buffers frames in a small RX FIFO.
- Valid/ready handshakes on both the TX and RX user sides.
- Sits between the system bus logic and the serial pins.

---
 rtl/uart_xcvr_p.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_xcvr_p.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xcvr_p.sv
// Parametrised full-duplex UART: run-time parity/stop/baud, 16x oversampled RX with a small FIFO.
// Define UART_LOOPBACK_EN to add the 'loopback' port that routes tx back into the receiver.
module uart_xcvr_p #(
  parameter int DATA_WIDTH    = 8,
  parameter int RX_FIFO_DEPTH = 4,
  parameter int DIV_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef UART_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx,
  input  logic                  rx,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  input  logic                  rx_ready,
  output logic                  rx_overrun
);

  localparam int CNT_W = DIV_WIDTH + 4;
  localparam int BW    = $clog2(DATA_WIDTH);
  localparam int AW    = $clog2(RX_FIFO_DEPTH);
  localparam int EW    = DATA_WIDTH + 2;

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;

  tx_state_t             tx_state;
  logic                  tx_line;
  logic [CNT_W-1:0]      tx_cnt;
  logic [BW-1:0]         tx_bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par;
  logic                  tx_par_en;
  logic [DIV_WIDTH-1:0]  tx_cfg_div;
  logic                  tx_cfg_stop2;
  logic                  tx_stop_second;
  logic                  rx_in;

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_line : rx;
  assign tx    = loopback ? 1'b1 : tx_line;
`else
  assign rx_in = rx;
  assign tx    = tx_line;
`endif

  // tx_cnt counts down the cycles of the current bit; {div,4'hF} is 16*(div+1)-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state       <= T_IDLE;
      tx_line        <= 1'b1;
      tx_ready       <= 1'b1;
      tx_cnt         <= '0;
      tx_bit_cnt     <= '0;
      tx_shift       <= '0;
      tx_par         <= 1'b0;
      tx_par_en      <= 1'b0;
      tx_cfg_div     <= '0;
      tx_cfg_stop2   <= 1'b0;
      tx_stop_second <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      tx_state       <= T_START;
      tx_line        <= 1'b0;
      tx_ready       <= 1'b0;
      tx_cnt         <= {baud_div, 4'hF};
      tx_bit_cnt     <= '0;
      tx_shift       <= tx_data;
      tx_par         <= (^tx_data) ^ (parity_mode == 2'b10);
      tx_par_en      <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      tx_cfg_div     <= baud_div;
      tx_cfg_stop2   <= stop2;
      tx_stop_second <= 1'b0;
    end else begin
      if (tx_state != T_IDLE)
        tx_cnt <= (tx_cnt == '0) ? {tx_cfg_div, 4'hF} : tx_cnt - 1'b1;
      // Raise ready one cycle early so it is visible in the final stop cycle.
      if (tx_state == T_STOP && tx_cnt == CNT_W'(1) && (!tx_cfg_stop2 || tx_stop_second))
        tx_ready <= 1'b1;
      if (tx_cnt == '0) begin
        case (tx_state)
          T_START: begin
            tx_state <= T_DATA;
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
          T_DATA: begin
            if (tx_bit_cnt == BW'(DATA_WIDTH - 1)) begin
              tx_state <= tx_par_en ? T_PARITY : T_STOP;
              tx_line  <= tx_par_en ? tx_par : 1'b1;
            end else begin
              tx_bit_cnt <= tx_bit_cnt + 1'b1;
              tx_line    <= tx_shift[0];
              tx_shift   <= tx_shift >> 1;
            end
          end
          T_PARITY: begin
            tx_state <= T_STOP;
            tx_line  <= 1'b1;
          end
          T_STOP: begin
            if (tx_cfg_stop2 && !tx_stop_second)
              tx_stop_second <= 1'b1;
            else
              tx_state <= T_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  rx_state_t             rx_state;
  logic                  rx_s1;
  logic                  rx_sync;
  logic                  rx_prev;
  logic [DIV_WIDTH-1:0]  rx_div_cnt;
  logic [3:0]            rx_tick_cnt;
  logic [BW-1:0]         rx_bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_perr;
  logic                  rx_ferr;
  logic [DIV_WIDTH-1:0]  rx_cfg_div;
  logic                  rx_par_en;
  logic                  rx_par_odd;
  logic                  rx_cfg_stop2;
  logic                  rx_stop_second;
  logic                  rx_tick;
  logic                  push;
  logic [EW-1:0]         push_entry;

  assign rx_tick    = (rx_div_cnt == rx_cfg_div);
  assign push       = (rx_state == R_STOP) && rx_tick && (rx_tick_cnt == 4'd15) &&
                      (!rx_cfg_stop2 || rx_stop_second);
  assign push_entry = {rx_shift, rx_perr, rx_ferr | ~rx_sync};

  // Start is sampled after 8 ticks (mid start bit); every later sample lands 16 ticks on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1          <= 1'b1;
      rx_sync        <= 1'b1;
      rx_prev        <= 1'b1;
      rx_state       <= R_IDLE;
      rx_div_cnt     <= '0;
      rx_tick_cnt    <= '0;
      rx_bit_cnt     <= '0;
      rx_shift       <= '0;
      rx_perr        <= 1'b0;
      rx_ferr        <= 1'b0;
      rx_cfg_div     <= '0;
      rx_par_en      <= 1'b0;
      rx_par_odd     <= 1'b0;
      rx_cfg_stop2   <= 1'b0;
      rx_stop_second <= 1'b0;
    end else begin
      rx_s1   <= rx_in;
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
      if (rx_state == R_IDLE) begin
        if (rx_prev && !rx_sync) begin
          rx_state       <= R_START;
          rx_div_cnt     <= '0;
          rx_tick_cnt    <= '0;
          rx_bit_cnt     <= '0;
          rx_perr        <= 1'b0;
          rx_ferr        <= 1'b0;
          rx_cfg_div     <= baud_div;
          rx_par_en      <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
          rx_par_odd     <= (parity_mode == 2'b10);
          rx_cfg_stop2   <= stop2;
          rx_stop_second <= 1'b0;
        end
      end else begin
        rx_div_cnt <= rx_tick ? '0 : rx_div_cnt + 1'b1;
        if (rx_tick) begin
          rx_tick_cnt <= rx_tick_cnt + 1'b1;
          case (rx_state)
            R_START: begin
              if (rx_tick_cnt == 4'd7) begin
                rx_tick_cnt <= '0;
                rx_state    <= rx_sync ? R_IDLE : R_DATA;
              end
            end
            R_DATA: begin
              if (rx_tick_cnt == 4'd15) begin
                rx_shift <= {rx_sync, rx_shift[DATA_WIDTH-1:1]};
                if (rx_bit_cnt == BW'(DATA_WIDTH - 1))
                  rx_state <= rx_par_en ? R_PARITY : R_STOP;
                else
                  rx_bit_cnt <= rx_bit_cnt + 1'b1;
              end
            end
            R_PARITY: begin
              if (rx_tick_cnt == 4'd15) begin
                rx_perr  <= rx_sync != ((^rx_shift) ^ rx_par_odd);
                rx_state <= R_STOP;
              end
            end
            R_STOP: begin
              if (rx_tick_cnt == 4'd15) begin
                rx_ferr <= rx_ferr | ~rx_sync;
                if (rx_cfg_stop2 && !rx_stop_second)
                  rx_stop_second <= 1'b1;
                else
                  rx_state <= R_IDLE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  logic [EW-1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push_ok;
  logic [AW:0]   next_count;
  logic [AW:0]   remaining;
  logic [EW-1:0] head_next;

  // A simultaneous pop frees a slot, so a push into a full FIFO still succeeds.
  always_comb begin
    pop        = rx_valid && rx_ready;
    push_ok    = push && ((count != (AW+1)'(RX_FIFO_DEPTH)) || pop);
    next_count = count + (AW+1)'(push_ok) - (AW+1)'(pop);
    remaining  = count - (AW+1)'(pop);
    head_next  = (remaining == '0) ? push_entry : mem[rd_ptr + AW'(pop)];
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count      <= next_count;
      rx_valid   <= (next_count != '0);
      rx_overrun <= push && !push_ok;
      if (next_count != '0)
        {rx_data, rx_parity_err, rx_frame_err} <= head_next;
    end
  end

endmodule

// File: tb/tb_uart_xcvr_p.sv
// Directed self-checking bench for uart_xcvr_p (default build, baud_div=0 so one bit = 16 clocks).
module tb_uart_xcvr_p;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = '0;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop2 = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready;
  logic        tx;
  logic        rx_line;
  logic        rx_drv = 1'b1;
  logic        loop_sel = 1'b0;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic        rx_ready = 1'b0;
  logic        rx_overrun;

  int errors = 0;
  int checks = 0;
  int overrun_count = 0;

  always #5 clk = ~clk;

  assign rx_line = loop_sel ? tx : rx_drv;

  uart_xcvr_p dut (
    .clk          (clk),
    .reset        (reset),
    .baud_div     (baud_div),
    .parity_mode  (parity_mode),
    .stop2        (stop2),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .rx           (rx_line),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun)
  );

  always @(negedge clk) if (rx_overrun) overrun_count++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    repeat (16) @(negedge clk);
  endtask

  // Drives one serial frame on rx_drv, starting and ending on a falling clock edge.
  task automatic applyStimulus(input logic [7:0] data, input bit has_par, input bit par_bit, input bit stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (has_par) drive_bit(par_bit);
    drive_bit(stop_bit);
    rx_drv = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] data);
    int waited = 0;
    while (!tx_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("send_tx_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = data;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [9:0]  frame;
    logic [7:0]  rx_got [2];
    logic [1:0]  err_got [2];
    int          acc_cycle [2];
    int          n_acc;
    int          n_rx;
    int          low_cnt;
    int          ov_before;
    bit          will_acc;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_errs", {30'd0, rx_parity_err, rx_frame_err}, 32'd0);
    checkOutput("reset_overrun", {31'd0, rx_overrun}, 32'd0);

    // Frame bits A5: start 0, data LSB first, stop 1; check first and last cycle of each bit.
    frame = {1'b1, 8'hA5, 1'b0};
    send_tx(8'hA5);
    low_cnt = 0;
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      if ((c - 1) % 16 == 0 || (c - 1) % 16 == 15)
        checkOutput($sformatf("t1_tx_bit%0d_c%0d", (c - 1) / 16, c), {31'd0, tx}, {31'd0, frame[(c - 1) / 16]});
      if (!tx_ready) low_cnt++;
    end
    checkOutput("t1_ready_low_cycles", low_cnt, 32'd159);
    @(negedge clk);
    checkOutput("t1_tx_idle", {31'd0, tx}, 32'd1);

    loop_sel = 1'b1;
    rx_ready = 1'b1;
    n_acc = 0;
    n_rx = 0;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    for (int c = 0; c < 450; c++) begin
      will_acc = tx_valid && tx_ready;
      if (rx_valid && n_rx < 2) begin
        rx_got[n_rx]  = rx_data;
        err_got[n_rx] = {rx_parity_err, rx_frame_err};
      end
      if (rx_valid) n_rx++;
      @(posedge clk);
      #1;
      if (will_acc && n_acc < 2) begin
        acc_cycle[n_acc] = c;
        n_acc++;
        if (n_acc == 1) tx_data = 8'hAB;
        else tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    checkOutput("t2_accepts", n_acc, 32'd2);
    if (n_acc == 2) checkOutput("t2_no_gap", acc_cycle[1] - acc_cycle[0], 32'd160);
    checkOutput("t2_rx_count", n_rx, 32'd2);
    if (n_rx >= 2) begin
      checkOutput("t2_rx0", {24'd0, rx_got[0]}, 32'hA5);
      checkOutput("t2_rx1", {24'd0, rx_got[1]}, 32'hAB);
      checkOutput("t2_err0", {30'd0, err_got[0]}, 32'd0);
      checkOutput("t2_err1", {30'd0, err_got[1]}, 32'd0);
    end

    loop_sel = 1'b0;
    rx_ready = 1'b0;
    parity_mode = 2'b01;
    send_tx(8'h07);
    repeat (153) @(negedge clk);
    checkOutput("t3_tx_parity_bit", {31'd0, tx}, 32'd1);
    repeat (30) @(negedge clk);
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("t3_rx_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("t3_rx_data", {24'd0, rx_data}, 32'h07);
    checkOutput("t3_parity_err", {31'd0, rx_parity_err}, 32'd1);
    checkOutput("t3_frame_err", {31'd0, rx_frame_err}, 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checkOutput("t3_popped", {31'd0, rx_valid}, 32'd0);
    checkOutput("t3_data_held", {24'd0, rx_data}, 32'h07);

    parity_mode = 2'b00;
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("t4_rx_data", {24'd0, rx_data}, 32'h3C);
    checkOutput("t4_frame_err", {31'd0, rx_frame_err}, 32'd1);
    checkOutput("t4_parity_err", {31'd0, rx_parity_err}, 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("t4_glitch_nothing", {31'd0, rx_valid}, 32'd0);

    ov_before = overrun_count;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(i[7:0], 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
    end
    checkOutput("t5_no_overrun_yet", overrun_count - ov_before, 32'd0);
    checkOutput("t5_full_head", {24'd0, rx_data}, 32'h01);
    applyStimulus(8'h05, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("t5_overrun_once", overrun_count - ov_before, 32'd1);
    rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("t5_drain%0d_valid", i), {31'd0, rx_valid}, 32'd1);
      checkOutput($sformatf("t5_drain%0d_data", i), {24'd0, rx_data}, i);
      @(negedge clk);
    end
    checkOutput("t5_empty", {31'd0, rx_valid}, 32'd0);
    checkOutput("t5_data_held", {24'd0, rx_data}, 32'h04);
    rx_ready = 1'b0;

    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t6_tx_busy", {31'd0, tx_ready}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("t6_reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("t6_reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("t6_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("t6_reset_rx_data", {24'd0, rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("t6_no_partial", {31'd0, rx_valid}, 32'd0);
    loop_sel = 1'b1;
    @(negedge clk);
    send_tx(8'h5A);
    repeat (200) @(negedge clk);
    checkOutput("t6_rx_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("t6_rx_data", {24'd0, rx_data}, 32'h5A);
    checkOutput("t6_rx_errs", {30'd0, rx_parity_err, rx_frame_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
